// File: rtl/if_pc_redirect_if.sv
// Fetch-side bundle between the IF stage, the ID-stage branch compare and the IF/ID register.
// The core/bench drives through master; the PC/IF-ID block sits on slave.
interface if_pc_redirect_if #(
    parameter int unsigned N = 32
);
    logic         stall;
    logic         id_branch;
    logic         id_equal;
    logic [N-1:0] id_target;
    logic [31:0]  imem_instr;
    logic [N-1:0] pc_out;
    logic [N-1:0] ifid_pc;
    logic [31:0]  ifid_instr;
    logic         ifid_valid;
    logic         flush;
    logic [N-1:0] br_total;
    logic [N-1:0] br_taken;

    modport master (
        output stall, id_branch, id_equal, id_target, imem_instr,
        input  pc_out, ifid_pc, ifid_instr, ifid_valid, flush, br_total, br_taken
    );

    modport slave (
        input  stall, id_branch, id_equal, id_target, imem_instr,
        output pc_out, ifid_pc, ifid_instr, ifid_valid, flush, br_total, br_taken
    );
endinterface

// File: rtl/if_pc_redirect.sv
// IF-stage PC and IF/ID register with predict-not-taken fetch and one-bubble branch redirect.
// Define BR_STATS_EN to build the saturating branch-resolved/branch-taken counters.
module if_pc_redirect #(
    parameter int unsigned   N        = 32,
    parameter logic [N-1:0]  RESET_PC = '0,
    parameter logic [31:0]   NOP      = 32'h0000_0013
) (
    input logic             clk,
    input logic             rst_n,
    if_pc_redirect_if.slave bus
);

    logic         taken;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic         ifid_valid_q, ifid_valid_d;

    assign taken = bus.id_branch & bus.id_equal;

    // Redirect wins over stall: the squashed slot would otherwise hold a wrong-path fetch.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        if (taken) begin
            pc_d         = {bus.id_target[N-1:2], 2'b00};
            ifid_pc_d    = '0;
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
        end else if (!bus.stall) begin
            pc_d         = pc_q + N'(4);
            ifid_pc_d    = pc_q;
            ifid_instr_d = bus.imem_instr;
            ifid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign bus.flush      = taken;
    assign bus.pc_out     = pc_q;
    assign bus.ifid_pc    = ifid_pc_q;
    assign bus.ifid_instr = ifid_instr_q;
    assign bus.ifid_valid = ifid_valid_q;

`ifdef BR_STATS_EN
    logic         count_br;
    logic [N-1:0] br_total_q, br_total_d;
    logic [N-1:0] br_taken_q, br_taken_d;

    // A stalled branch is re-presented next cycle, so count it only when it resolves.
    assign count_br = bus.id_branch & (~bus.stall | taken);

    always_comb begin
        br_total_d = br_total_q;
        br_taken_d = br_taken_q;
        if (count_br && (br_total_q != '1)) begin
            br_total_d = br_total_q + N'(1);
        end
        if (taken && (br_taken_q != '1)) begin
            br_taken_d = br_taken_q + N'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_total_q <= '0;
            br_taken_q <= '0;
        end else begin
            br_total_q <= br_total_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign bus.br_total = br_total_q;
    assign bus.br_taken = br_taken_q;
`else
    assign bus.br_total = '0;
    assign bus.br_taken = '0;
`endif

endmodule
